// File: rtl/miriscv_fetch_stage.sv
// Instruction fetch stage: issues word-aligned fetches, tracks outstanding requests,
// buffers responses in an in-order FIFO and drops stale responses after a redirect or boot-load.
module miriscv_fetch_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,

  output logic [31:0] f_instr_o,
  output logic [31:0] f_current_pc_o,
  output logic [31:0] f_next_pc_o,
  output logic        f_valid_o,

  input  logic [31:0] cu_pc_bra_i,
  input  logic        cu_boot_addr_load_en_i,
  input  logic        cu_stall_f_i,
  input  logic        cu_kill_f_i
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthLim = FIFO_DEPTH[CntW:0];
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [31:0]     instr_mem_q [FIFO_DEPTH];
  logic [31:0]     pc_mem_q    [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [CntW-1:0] disc_cnt_q, disc_cnt_d;
  logic [CntW:0]   inflight;

  logic redirect, flush, pop, push, drop, grant, rsp_dec;

  assign f_valid_o = (count_q != '0);
  assign redirect  = cu_kill_f_i && !cu_stall_f_i && f_valid_o;
  assign flush     = cu_boot_addr_load_en_i || redirect;
  assign pop       = f_valid_o && !cu_stall_f_i;

  // Requested-but-unanswered plus buffered entries never exceed the FIFO, so a push always fits.
  assign inflight     = {1'b0, out_cnt_q} + {1'b0, count_q};
  assign instr_req_o  = !rst_i && !flush && (inflight < DepthLim);
  assign instr_addr_o = pc_q;
  assign grant        = instr_req_o && instr_gnt_i;

  assign rsp_dec = instr_rvalid_i && (out_cnt_q != '0);
  assign drop    = instr_rvalid_i && (disc_cnt_q != '0);
  assign push    = instr_rvalid_i && !drop && !flush;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    disc_cnt_d = disc_cnt_q;
    out_cnt_d  = out_cnt_q + CntW'(grant) - CntW'(rsp_dec);

    if (grant) pc_d = pc_q + 32'd4;
    if (drop)  disc_cnt_d = disc_cnt_q - CntW'(1);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push) - CntW'(pop);

    // Every response still owed by memory belongs to the abandoned stream.
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      disc_cnt_d = out_cnt_q - CntW'(rsp_dec);
      pc_d       = cu_boot_addr_load_en_i ? BOOT_ADDR : cu_pc_bra_i;
      rsp_pc_d   = pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= BOOT_ADDR;
      rsp_pc_q   <= BOOT_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      instr_mem_q[wr_ptr_q] <= instr_rdata_i;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  assign f_instr_o      = f_valid_o ? instr_mem_q[rd_ptr_q] : Nop;
  assign f_current_pc_o = f_valid_o ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign f_next_pc_o    = f_current_pc_o + 32'd4;

endmodule

// File: tb/tb_miriscv_fetch_stage.sv
// Directed bench for miriscv_fetch_stage: table-driven warm-up/stall phase, then hand-written
// redirect, wrap-around, boot-load and reset sequences against an in-order 1-cycle memory model.
module tb_miriscv_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b1;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic [31:0] f_instr_o, f_current_pc_o, f_next_pc_o;
  logic        f_valid_o;
  logic [31:0] cu_pc_bra_i = '0;
  logic        cu_boot_addr_load_en_i = 1'b0;
  logic        cu_stall_f_i = 1'b0;
  logic        cu_kill_f_i = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        rsp_en = 1'b1;
  logic [31:0] pend_q [$];

  always #5 clk = ~clk;

  miriscv_fetch_stage #(
    .BOOT_ADDR (32'h0000_0080),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .instr_req_o           (instr_req_o),
    .instr_addr_o          (instr_addr_o),
    .instr_gnt_i           (instr_gnt_i),
    .instr_rvalid_i        (instr_rvalid_i),
    .instr_rdata_i         (instr_rdata_i),
    .f_instr_o             (f_instr_o),
    .f_current_pc_o        (f_current_pc_o),
    .f_next_pc_o           (f_next_pc_o),
    .f_valid_o             (f_valid_o),
    .cu_pc_bra_i           (cu_pc_bra_i),
    .cu_boot_addr_load_en_i(cu_boot_addr_load_en_i),
    .cu_stall_f_i          (cu_stall_f_i),
    .cu_kill_f_i           (cu_kill_f_i)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle; memory answers each grant on the following cycle when rsp_en is set.
  task automatic tick();
    logic fire;
    logic [31:0] fa;
    logic rv;
    #1;
    fire = (instr_req_o === 1'b1) && instr_gnt_i;
    fa   = instr_addr_o;
    rv   = instr_rvalid_i;
    @(posedge clk);
    #1;
    if (rst_i) begin
      pend_q.delete();
    end else begin
      if (rv && pend_q.size() > 0) void'(pend_q.pop_front());
      if (fire) pend_q.push_back(fa);
    end
    @(negedge clk);
    if (rsp_en && !rst_i && pend_q.size() > 0) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_data(pend_q[0]);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end
  endtask

  task automatic check_req(input string tag, input logic er, input logic [31:0] ea);
    #1;
    check({tag, " req"}, 32'(instr_req_o), 32'(er));
    if (er) check({tag, " addr"}, instr_addr_o, ea);
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] epc);
    logic [31:0] pc;
    pc = ev ? epc : 32'h0;
    check({tag, " valid"}, 32'(f_valid_o), 32'(ev));
    check({tag, " pc"}, f_current_pc_o, pc);
    check({tag, " next_pc"}, f_next_pc_o, pc + 32'd4);
    check({tag, " instr"}, f_instr_o, ev ? mem_data(epc) : 32'h0000_0013);
  endtask

  task automatic drive(input logic st, input logic k, input logic bt, input logic g,
                       input logic [31:0] bra);
    cu_stall_f_i           = st;
    cu_kill_f_i            = k;
    cu_boot_addr_load_en_i = bt;
    instr_gnt_i            = g;
    cu_pc_bra_i            = bra;
  endtask

  typedef struct {
    logic        boot;
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [20];

  initial begin
    // Boot-load, warm-up stream, 10-cycle stall filling the buffer, release.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h84, 1'b1, 32'h80};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h88, 1'b1, 32'h84};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h8C, 1'b1, 32'h88};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h90, 1'b1, 32'h8C};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h94, 1'b1, 32'h90};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h98, 1'b1, 32'h90};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h9C, 1'b1, 32'h90};
    for (int i = 10; i < 18; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 32'hA0, 1'b1, 32'h90};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 32'hA0, 1'b1, 32'h94};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 32'hA0, 1'b1, 32'h98};

    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    rst_i = 1'b1;
    tick();
    check_req("reset", 1'b0, 32'h0);
    check_out("reset", 1'b0, 32'h0);
    tick();
    rst_i = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stall, 1'b0, vecs[i].boot, 1'b1, 32'h0);
      check_req($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
      tick();
      check_out($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // Fresh start, then redirect to 0x200 with two responses outstanding.
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_req("rst1", 1'b0, 32'h0);
    tick();
    rst_i = 1'b0;
    check_out("rst1", 1'b0, 32'h0);
    check_req("a1", 1'b1, 32'h80);  tick(); check_out("a1", 1'b0, 32'h0);
    rsp_en = 1'b0;
    check_req("a2", 1'b1, 32'h84);  tick(); check_out("a2", 1'b1, 32'h80);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    check_req("a3", 1'b1, 32'h88);  tick(); check_out("a3", 1'b1, 32'h80);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    rsp_en = 1'b1;
    check_req("a4", 1'b0, 32'h0);   tick(); check_out("a4", 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_req("a5", 1'b1, 32'h200); tick(); check_out("a5", 1'b0, 32'h0);
    check_req("a6", 1'b1, 32'h204); tick(); check_out("a6", 1'b0, 32'h0);
    check_req("a7", 1'b1, 32'h208); tick(); check_out("a7", 1'b1, 32'h200);

    // Response and redirect in the same cycle with one outstanding: nothing left to discard.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_req("b8", 1'b1, 32'h20C); tick(); check_out("b8", 1'b1, 32'h204);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h300);
    check_req("b9", 1'b0, 32'h0);   tick(); check_out("b9", 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h700);  // kill with empty buffer is ignored
    check_req("b10", 1'b1, 32'h300); tick(); check_out("b10", 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_req("b11", 1'b1, 32'h304); tick(); check_out("b11", 1'b1, 32'h300);

    // Address wrap-around past 0xFFFF_FFFC.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check_req("c12", 1'b0, 32'h0);  tick(); check_out("c12", 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_req("c13", 1'b1, 32'hFFFF_FFFC); tick(); check_out("c13", 1'b0, 32'h0);
    check_req("c14", 1'b1, 32'h0);  tick(); check_out("c14", 1'b1, 32'hFFFF_FFFC);
    check_req("c15", 1'b1, 32'h4);  tick(); check_out("c15", 1'b1, 32'h0);

    // Boot-load wins over a simultaneous redirect.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h500);
    check_req("d16", 1'b0, 32'h0);  tick(); check_out("d16", 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_req("d17", 1'b1, 32'h80); tick(); check_out("d17", 1'b0, 32'h0);
    check_req("d18", 1'b1, 32'h84); tick(); check_out("d18", 1'b1, 32'h80);

    // Kill while stalled is ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h600);
    check_req("e19", 1'b1, 32'h88); tick(); check_out("e19", 1'b1, 32'h80);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_req("e20", 1'b1, 32'h8C); tick(); check_out("e20", 1'b1, 32'h84);

    // Reset mid-stream abandons everything in flight.
    rst_i = 1'b1;
    check_req("rst2", 1'b0, 32'h0);
    tick();
    rst_i = 1'b0;
    check_out("rst2", 1'b0, 32'h0);
    check_req("r1", 1'b1, 32'h80);  tick(); check_out("r1", 1'b0, 32'h0);
    check_req("r2", 1'b1, 32'h84);  tick(); check_out("r2", 1'b1, 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miriscv_fetch_stage.md
MIRISCV_FETCH_STAGE -- requirements
Module: miriscv_fetch_stage

Interface
REQ-001 Parameter: BOOT_ADDR, 32'h0000_0000, PC loaded while boot-load is active.
REQ-002 Parameter: FIFO_DEPTH, 4, instruction buffer entries and maximum outstanding requests; power of two, at least 2.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 instr_req_o  out  1  instruction fetch request.
REQ-006 instr_addr_o  out  XLEN  fetch address, word aligned.
REQ-007 instr_gnt_i  in  1  request accepted in the cycle where instr_req_o && instr_gnt_i.
REQ-008 instr_rvalid_i  in  1  response valid; responses arrive in request order, at least 1 cycle after grant.
REQ-009 instr_rdata_i  in  ILEN  fetched instruction word.
REQ-010 f_instr_o  out  ILEN  instruction presented to decode.
REQ-011 f_current_pc_o  out  XLEN  PC of f_instr_o.
REQ-012 f_next_pc_o  out  XLEN  f_current_pc_o + 4.
REQ-013 f_valid_o  out  1  head entry is a real fetched instruction.
REQ-014 cu_pc_bra_i  in  XLEN  redirect target.
REQ-015 cu_boot_addr_load_en_i  in  1  boot-load hold.
REQ-016 cu_stall_f_i  in  1  decode is not consuming this cycle.
REQ-017 cu_kill_f_i  in  1  redirect request from decode.

Function
REQ-018 The block SHALL hold a fetch PC register, an in-order FIFO of {instr, pc} pairs, an outstanding-request counter (out_cnt) and a discard counter (disc_cnt).
REQ-019 instr_req_o SHALL be 1 iff not boot-load, not redirect-this-cycle, and out_cnt + fifo_count < FIFO_DEPTH; instr_addr_o = fetch PC.
REQ-020 On grant, the fetch PC SHALL advance by 4 (32-bit wrap-around, no carry) and out_cnt SHALL increment.
REQ-021 On instr_rvalid_i, out_cnt SHALL decrement; if disc_cnt > 0, the response SHALL be dropped and disc_cnt decremented, otherwise {instr_rdata_i, pc} SHALL be pushed, where pc comes from a response-PC tracker incremented by 4 per accepted response.
REQ-022 A grant and a response in the same cycle SHALL leave out_cnt unchanged.
REQ-023 FIFO non-empty: f_valid_o=1, f_instr_o/f_current_pc_o = head entry; registered outputs with no rdata-to-output combinational bypass, so a response is visible the cycle after instr_rvalid_i.
REQ-024 FIFO empty: f_valid_o=0, f_instr_o=32'h0000_0013 (NOP), f_current_pc_o=0, f_next_pc_o=4.
REQ-025 Pop SHALL occur when f_valid_o && !cu_stall_f_i.
REQ-026 Redirect = cu_kill_f_i && !cu_stall_f_i && f_valid_o; in that cycle the head SHALL be popped, the FIFO flushed, fetch PC and response-PC tracker loaded with cu_pc_bra_i, disc_cnt set to out_cnt minus instr_rvalid_i, and no request issued.
REQ-027 cu_kill_f_i while stalled or while FIFO empty SHALL be ignored.
REQ-028 Requests to the new target SHALL be allowed from the cycle after redirect even while disc_cnt > 0.
REQ-029 While cu_boot_addr_load_en_i=1: fetch PC and tracker SHALL be loaded with BOOT_ADDR, FIFO flushed, disc_cnt set to out_cnt minus instr_rvalid_i, no request issued; boot-load has priority over redirect.
REQ-030 Push to a full FIFO SHALL be impossible by construction (REQ-019); simultaneous push and pop SHALL keep the count unchanged.

Reset
REQ-031 rst_i=1 SHALL set fetch PC=BOOT_ADDR, FIFO empty, out_cnt=0, disc_cnt=0, instr_req_o=0; outputs therefore per REQ-024.
REQ-032 rst_i asserted mid-operation SHALL abandon in-flight responses; responses arriving after reset release SHALL be treated as new (no discard).

Verification
REQ-033 Reset, then boot-load high 2 cycles, BOOT_ADDR=0x80, gnt=1, 1-cycle response -> first request at 0x80 on the cycle boot-load drops; f_valid_o=1 with pc=0x80 two cycles later.
REQ-034 Continuous gnt, 1-cycle rvalid, no stall -> f_current_pc_o sequence 0x80, 0x84, 0x88, ... with no bubble after warm-up; f_next_pc_o = pc+4.
REQ-035 cu_stall_f_i held 10 cycles -> exactly 4 requests outstanding or buffered; instr_req_o=0 afterwards; head unchanged.
REQ-036 Redirect to 0x200 with 2 responses outstanding -> both dropped; next f_valid_o entry has pc=0x200.
REQ-037 Fetch PC 0xFFFF_FFFC granted -> next request address 0x0000_0000.
REQ-038 rvalid and redirect in the same cycle with out_cnt=1 -> disc_cnt=0; that response is not pushed.
